// File: rtl/dino_gfx_pkg.sv
// Shared graphics definitions for the dino VGA path.
// Contents:
//   RGB_W            width of a packed {R[1:0],G[1:0],B[1:0]} pixel
//   COL_*            named colour constants
//   DEFAULT_PALETTE  packed per-layer colours; layer i sits at [6*i+5:6*i]
//   night_apply()    inverts a colour when night mode is active
package dino_gfx_pkg;

  localparam int RGB_W = 6;

  localparam logic [RGB_W-1:0] COL_BLACK = 6'b000000;
  localparam logic [RGB_W-1:0] COL_WHITE = 6'b111111;
  localparam logic [RGB_W-1:0] COL_RED   = 6'b110000;
  localparam logic [RGB_W-1:0] COL_GREEN = 6'b001100;
  localparam logic [RGB_W-1:0] COL_GREY  = 6'b010101;

  // Layer 0 green, layer 1 red, layer 2 white, layer 3 grey (== 24'h57FC0C).
  localparam logic [4*RGB_W-1:0] DEFAULT_PALETTE = {COL_GREY, COL_WHITE, COL_RED, COL_GREEN};

  // Night mode is a plain bitwise inversion of the visible colour.
  function automatic logic [RGB_W-1:0] night_apply(input logic [RGB_W-1:0] colour,
                                                   input logic             night);
    return colour ^ {RGB_W{night}};
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// Fixed-priority encoder for the sprite layers.
// Ports:
//   vis_i  per-layer visibility, bit 0 = highest priority
//   hit_o  at least one layer is visible
//   idx_o  index of the lowest-numbered visible layer (0 when hit_o is low)
module layer_priority_enc
  import dino_gfx_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [NUM_LAYERS-1:0] vis_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o
);

  // Scan from the lowest priority upwards so the lowest set index wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = {IDX_W{1'b0}};
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      hit_o = hit_o | vis_i[i];
      idx_o = vis_i[i] ? IDX_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor with per-frame collision detection.
// Two-stage pipeline: stage 1 registers per-layer visibility (colour, enable,
// blink gating) and display_on; stage 2 resolves priority to a colour, applies
// night inversion and detects A/B group overlap. Frame-level state (sticky
// overlap, collision_frame, night, blink counter) updates on i_frame_end.
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   i_layer_color       raw per-layer pixel, bit i = layer i
//   i_layer_enable      per-layer enable
//   i_display_on        high inside the visible area
//   i_frame_end         one-cycle pulse on the last cycle of a frame
//   i_night_req         requested night mode, taken at frame end
//   i_blink_en          enables blinking of BLINK_MASK layers
//   o_rgb               composited pixel, 2 clocks after the inputs
//   o_collision         pulse on the first A/B overlap of a frame
//   o_collision_frame   high for the frame after one that had an overlap
//   o_night             night mode currently applied
module layer_compositor
  import dino_gfx_pkg::*;
#(
  parameter int                      NUM_LAYERS     = 4,
  parameter logic [6*NUM_LAYERS-1:0] LAYER_PALETTE  = (6*NUM_LAYERS)'(DEFAULT_PALETTE),
  parameter logic [RGB_W-1:0]        BG_COLOR       = COL_BLACK,
  parameter logic [NUM_LAYERS-1:0]   COLLIDE_A_MASK = NUM_LAYERS'(4'b0001),
  parameter logic [NUM_LAYERS-1:0]   COLLIDE_B_MASK = NUM_LAYERS'(4'b0010),
  parameter logic [NUM_LAYERS-1:0]   BLINK_MASK     = NUM_LAYERS'(4'b0100),
  parameter int                      BLINK_LOG2     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_LAYERS-1:0] i_layer_color,
  input  logic [NUM_LAYERS-1:0] i_layer_enable,
  input  logic                  i_display_on,
  input  logic                  i_frame_end,
  input  logic                  i_night_req,
  input  logic                  i_blink_en,
  output logic [RGB_W-1:0]      o_rgb,
  output logic                  o_collision,
  output logic                  o_collision_frame,
  output logic                  o_night
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  // Stage 1
  logic [NUM_LAYERS-1:0] vis_q, vis_d;
  logic                  disp_q;
  logic                  blink_off_s;

  // Stage 2
  logic                  hit_s;
  logic [IDX_W-1:0]      idx_s;
  logic [RGB_W-1:0]      colour_s;
  logic [RGB_W-1:0]      rgb_q, rgb_d;
  logic                  ov_s;
  logic                  coll_q, coll_d;

  // Frame-level state
  logic                  sticky_q, sticky_d;
  logic                  coll_frame_q, coll_frame_d;
  logic                  night_q, night_d;
  logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;

  // Stage 1 visibility: blink-masked layers disappear while the counter MSB is set.
  always_comb begin
    blink_off_s = i_blink_en & blink_cnt_q[BLINK_LOG2-1];
    vis_d       = i_layer_color & i_layer_enable & ~(BLINK_MASK & {NUM_LAYERS{blink_off_s}});
  end

  layer_priority_enc #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_prio (
    .vis_i (vis_q),
    .hit_o (hit_s),
    .idx_o (idx_s)
  );

  // Stage 2 colour: palette of the winning layer, background otherwise; blanking is never inverted.
  always_comb begin
    colour_s = BG_COLOR;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      colour_s = (hit_s && (idx_s == IDX_W'(i))) ? LAYER_PALETTE[6*i +: 6] : colour_s;
    end
    rgb_d = disp_q ? night_apply(colour_s, night_q) : {RGB_W{1'b0}};
  end

  // Overlap detection; the sticky flag suppresses repeat pulses within a frame.
  always_comb begin
    ov_s   = disp_q & (|(vis_q & COLLIDE_A_MASK)) & (|(vis_q & COLLIDE_B_MASK));
    coll_d = ov_s & ~sticky_q;
  end

  // Frame-boundary updates; an overlap on the frame_end cycle belongs to the ending frame.
  always_comb begin
    sticky_d     = sticky_q;
    coll_frame_d = coll_frame_q;
    night_d      = night_q;
    blink_cnt_d  = blink_cnt_q;
    if (i_frame_end) begin
      sticky_d     = 1'b0;
      coll_frame_d = sticky_q | ov_s;
      night_d      = i_night_req;
      blink_cnt_d  = blink_cnt_q + BLINK_LOG2'(1);
    end else begin
      sticky_d     = sticky_q | ov_s;
    end
  end

  // All state registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vis_q        <= {NUM_LAYERS{1'b0}};
      disp_q       <= 1'b0;
      rgb_q        <= {RGB_W{1'b0}};
      coll_q       <= 1'b0;
      sticky_q     <= 1'b0;
      coll_frame_q <= 1'b0;
      night_q      <= 1'b0;
      blink_cnt_q  <= {BLINK_LOG2{1'b0}};
    end else begin
      vis_q        <= vis_d;
      disp_q       <= i_display_on;
      rgb_q        <= rgb_d;
      coll_q       <= coll_d;
      sticky_q     <= sticky_d;
      coll_frame_q <= coll_frame_d;
      night_q      <= night_d;
      blink_cnt_q  <= blink_cnt_d;
    end
  end

  assign o_rgb             = rgb_q;
  assign o_collision       = coll_q;
  assign o_collision_frame = coll_frame_q;
  assign o_night           = night_q;

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] color, en;
  logic       disp, frame_end, night_req, blink_en;
  logic [5:0] o_rgb;
  logic       o_collision, o_collision_frame, o_night;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  layer_compositor dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_layer_color     (color),
    .i_layer_enable    (en),
    .i_display_on      (disp),
    .i_frame_end       (frame_end),
    .i_night_req       (night_req),
    .i_blink_en        (blink_en),
    .o_rgb             (o_rgb),
    .o_collision       (o_collision),
    .o_collision_frame (o_collision_frame),
    .o_night           (o_night)
  );

  // ---------------- reference model ----------------
  // Layer colours: 0 green, 1 red, 2 white, 3 grey; background black.
  localparam logic [5:0] PAL [4] = '{6'b001100, 6'b110000, 6'b111111, 6'b010101};

  int         m_frames;   // frames completed since reset
  bit         m_seen;     // overlap already seen in the current frame
  bit         m_night;
  logic [3:0] p_vis;      // visible layers captured one clock ago
  bit         p_disp;
  logic [5:0] exp_rgb;
  bit         exp_coll, exp_cf, exp_night;

  task automatic model_edge();
    logic [5:0] pix;
    bit         ov, hide;
    if (!rst_n) begin
      exp_rgb = 6'b0; exp_coll = 1'b0; exp_cf = 1'b0; exp_night = 1'b0;
      m_frames = 0; m_seen = 1'b0; m_night = 1'b0; p_vis = 4'b0; p_disp = 1'b0;
    end else begin
      hide = blink_en && ((m_frames % 16) >= 8);
      pix = 6'b000000;
      for (int i = 3; i >= 0; i--) if (p_vis[i]) pix = PAL[i];
      exp_rgb  = p_disp ? (pix ^ {6{m_night}}) : 6'b000000;
      ov       = p_disp && (p_vis[0] == 1'b1) && (p_vis[1] == 1'b1);
      exp_coll = ov && !m_seen;
      if (frame_end) begin
        exp_cf   = m_seen || ov;
        m_seen   = 1'b0;
        m_night  = night_req;
        m_frames = m_frames + 1;
      end else if (ov) begin
        m_seen = 1'b1;
      end
      exp_night = m_night;
      p_vis  = color & en & (hide ? 4'b1011 : 4'b1111);
      p_disp = disp;
    end
  endtask

  // Advance one clock, update the model at the edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] e, input logic d, input logic fe);
    color = c; en = e; disp = d; frame_end = fe;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'hF, 4'hF, 1'b1, 1'b0);
    night_req = 1'b1; blink_en = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (o_rgb !== 6'b0 || o_collision !== 1'b0 || o_collision_frame !== 1'b0 || o_night !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: rgb=%b coll=%b cf=%b night=%b, required all 0",
               o_rgb, o_collision, o_collision_frame, o_night);
    end
    night_req = 1'b0;
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_priority();
    drive(4'b0110, 4'hF, 1'b1, 1'b0);
    tick(); tick();
    n_checks++;
    if (o_rgb !== 6'b110000) begin
      n_errors++; $display("FAIL priority_red: rgb=%b required 110000", o_rgb);
    end
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    tick(); tick();
    n_checks++;
    if (o_rgb !== 6'b000000) begin
      n_errors++; $display("FAIL priority_bg: rgb=%b required 000000", o_rgb);
    end
  endtask

  task automatic test_enable_collision();
    int pulses;
    drive(4'b0011, 4'b1110, 1'b1, 1'b0);
    pulses = 0;
    repeat (5) begin
      tick();
      if (o_collision === 1'b1) pulses++;
    end
    n_checks++;
    if (o_rgb !== 6'b110000 || pulses != 0) begin
      n_errors++; $display("FAIL disabled_layer: rgb=%b pulses=%0d required 110000/0", o_rgb, pulses);
    end
    drive(4'b0011, 4'hF, 1'b1, 1'b0);
    pulses = 0;
    repeat (8) begin
      tick();
      if (o_collision === 1'b1) pulses++;
    end
    n_checks++;
    if (o_rgb !== 6'b001100 || pulses != 1) begin
      n_errors++; $display("FAIL single_pulse: rgb=%b pulses=%0d required 001100/1", o_rgb, pulses);
    end
  endtask

  task automatic test_frame_latch();
    // Overlap still in the pipe while this frame ends.
    drive(4'b0000, 4'hF, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (o_collision_frame !== 1'b1) begin
      n_errors++; $display("FAIL frame_latch_set: cf=%b required 1", o_collision_frame);
    end
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    repeat (4) tick();
    drive(4'b0000, 4'hF, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (o_collision_frame !== 1'b0) begin
      n_errors++; $display("FAIL frame_latch_clear: cf=%b required 0", o_collision_frame);
    end
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    repeat (3) tick();
    drive(4'b0011, 4'hF, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 4'hF, 1'b1, 1'b1);   // overlap reaches stage 2 on the frame_end cycle
    tick();
    n_checks++;
    if (o_collision_frame !== 1'b1 || o_collision !== 1'b1) begin
      n_errors++; $display("FAIL frame_end_overlap: cf=%b coll=%b required 1/1", o_collision_frame, o_collision);
    end
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_night();
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    night_req = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (o_night !== 1'b0 || o_rgb !== 6'b000000) begin
      n_errors++; $display("FAIL night_midframe: night=%b rgb=%b required 0/000000", o_night, o_rgb);
    end
    drive(4'b0000, 4'hF, 1'b1, 1'b1);
    tick();
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    tick(); tick();
    n_checks++;
    if (o_night !== 1'b1 || o_rgb !== 6'b111111) begin
      n_errors++; $display("FAIL night_applied: night=%b rgb=%b required 1/111111", o_night, o_rgb);
    end
    drive(4'b0000, 4'hF, 1'b0, 1'b0);
    tick(); tick();
    n_checks++;
    if (o_rgb !== 6'b000000) begin
      n_errors++; $display("FAIL night_blanking: rgb=%b required 000000", o_rgb);
    end
    night_req = 1'b0;
    drive(4'b0000, 4'hF, 1'b0, 1'b1);
    tick();
    drive(4'b0000, 4'hF, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_blink();
    logic [5:0] want;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    blink_en = 1'b1;
    for (int f = 0; f < 18; f++) begin
      drive(4'b1100, 4'hF, 1'b1, 1'b0);
      repeat (3) tick();
      want = ((f % 16) < 8) ? 6'b111111 : 6'b010101;
      n_checks++;
      if (o_rgb !== want) begin
        n_errors++; $display("FAIL blink_frame%0d: rgb=%b required %b", f, o_rgb, want);
      end
      drive(4'b1100, 4'hF, 1'b1, 1'b1);
      tick();
    end
    blink_en = 1'b0;
    drive(4'b0000, 4'hF, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_midframe_reset();
    drive(4'b0011, 4'hF, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (o_rgb !== 6'b0 || o_collision !== 1'b0 || o_collision_frame !== 1'b0 || o_night !== 1'b0) begin
      n_errors++; $display("FAIL midframe_reset: rgb=%b coll=%b cf=%b night=%b required all 0",
                           o_rgb, o_collision, o_collision_frame, o_night);
    end
    drive(4'b0000, 4'hF, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (o_collision !== 1'b0) begin
        n_errors++; $display("FAIL stale_pulse%0d: coll=%b required 0", i, o_collision);
      end
    end
  endtask

  task automatic test_random();
    int frame_len, pos;
    frame_len = 20; pos = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      color = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      disp  = ($urandom_range(0, 7) != 0);
      pos++;
      frame_end = (pos >= frame_len);
      if (frame_end) begin
        pos = 0; frame_len = $urandom_range(8, 30);
      end
      if ($urandom_range(0, 99) == 0) night_req = ~night_req;
      if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
      n_checks++;
      if (o_rgb !== exp_rgb || o_collision !== exp_coll || o_collision_frame !== exp_cf || o_night !== exp_night) begin
        n_errors++;
        $display("FAIL random_cyc%0d: rgb=%b coll=%b cf=%b night=%b required %b/%b/%b/%b",
                 cyc, o_rgb, o_collision, o_collision_frame, o_night, exp_rgb, exp_coll, exp_cf, exp_night);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; night_req = 1'b0; blink_en = 1'b0;
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    test_reset();
    test_priority();
    test_enable_collision();
    test_frame_latch();
    test_night();
    test_blink();
    test_midframe_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
